// File: rtl/led_pkg.sv
// Shared types and helpers for the LED frame streamer.
//   stream_state_t : frame streamer FSM states
//   RGB_W / CH_W   : pixel and per-channel widths
//   scale_ch()     : one-channel brightness scale, (c * (b + 1)) >> 8
package led_pkg;

  localparam int unsigned RGB_W = 24;
  localparam int unsigned CH_W  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain
  } stream_state_t;

  // b + 1 makes 255 an identity scale. 0 gives c >> 8, which is always 0 for 8-bit c.
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                               input logic [CH_W-1:0] b);
    logic [2*CH_W-1:0] p;
    p = {8'd0, c} * {7'd0, {1'b0, b} + 9'd1};
    return p[2*CH_W-1:CH_W];
  endfunction

endpackage

// File: rtl/led_scale.sv
// Combinational 3-channel brightness scaler.
//   rgb_i    : {R,G,B} input pixel
//   bright_i : global brightness, 0..255
//   rgb_o    : scaled {R,G,B}
module led_scale
  import led_pkg::*;
(
  input  logic [RGB_W-1:0] rgb_i,
  input  logic [CH_W-1:0]  bright_i,
  output logic [RGB_W-1:0] rgb_o
);

  always_comb begin
    rgb_o = {scale_ch(rgb_i[23:16], bright_i),
             scale_ch(rgb_i[15:8],  bright_i),
             scale_ch(rgb_i[7:0],   bright_i)};
  end

endmodule

// File: rtl/led_frame_streamer.sv
// Frame buffer plus streamer feeding a WS2812B serial driver.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   wr_en_i/addr/data     : pixel buffer write port (out-of-range addresses ignored)
//   brightness_i          : global brightness, latched when a frame starts
//   start_i               : request one frame (accepted only when idle and driver not busy)
//   drv_ready_o/drv_rgb_o : pixel offered to the driver
//   drv_busy_i            : driver busy, including its latch/reset gap
//   drv_latched_i         : driver took the offered pixel (1-cycle pulse)
//   frame_busy_o          : frame in progress
//   frame_done_o          : 1-cycle pulse once the driver has gone idle after the frame
module led_frame_streamer
  import led_pkg::*;
#(
  parameter  int unsigned NUM_LEDS = 16,
  localparam int unsigned AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [RGB_W-1:0] wr_data_i,
  input  logic [CH_W-1:0]  brightness_i,
  input  logic             start_i,
  output logic             drv_ready_o,
  output logic [RGB_W-1:0] drv_rgb_o,
  input  logic             drv_busy_i,
  input  logic             drv_latched_i,
  output logic             frame_busy_o,
  output logic             frame_done_o
);

  // Buffer is sized to the full address space so every index is in bounds;
  // entries at or above NUM_LEDS are never written.
  localparam int unsigned    Depth   = 1 << AW;
  localparam logic [AW-1:0] LastIdx = AW'(NUM_LEDS - 1);

  logic [RGB_W-1:0] pix_q [Depth];

  stream_state_t    state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d, fetch_idx;
  logic [CH_W-1:0]  bright_q, bright_d, scale_bright;
  logic [RGB_W-1:0] rgb_q, rgb_d, scaled;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_ok, accept, last_pix;

  assign wr_ok    = wr_en_i && (32'(wr_addr_i) < NUM_LEDS);
  assign accept   = start_i && !drv_busy_i;
  assign last_pix = (idx_q == LastIdx);

  // No reset: pixel contents survive rst. Async read returns the pre-write value.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      pix_q[wr_addr_i] <= wr_data_i;
    end
  end

  // In idle the scaler looks at pixel 0 with live brightness so the first pixel is
  // ready the cycle after acceptance; while streaming it prefetches idx + 1.
  always_comb begin
    if (state_q == StIdle) begin
      fetch_idx    = '0;
      scale_bright = brightness_i;
    end else begin
      fetch_idx    = idx_q + AW'(1);
      scale_bright = bright_q;
    end
  end

  led_scale u_scale (
    .rgb_i    (pix_q[fetch_idx]),
    .bright_i (scale_bright),
    .rgb_o    (scaled)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      bright_q <= '0;
      rgb_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bright_q <= bright_d;
      rgb_q    <= rgb_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StStream;
      StStream: if (drv_latched_i && last_pix) state_d = StDrain;
      StDrain:  if (!drv_busy_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    bright_d = bright_q;
    rgb_d    = rgb_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          idx_d    = '0;
          bright_d = brightness_i;
          rgb_d    = scaled;
          ready_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      StStream: begin
        if (drv_latched_i) begin
          if (last_pix) begin
            ready_d = 1'b0;
          end else begin
            idx_d = fetch_idx;
            rgb_d = scaled;
          end
        end
      end
      StDrain: begin
        if (!drv_busy_i) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign drv_ready_o  = ready_q;
  assign drv_rgb_o    = rgb_q;
  assign frame_busy_o = busy_q;
  assign frame_done_o = done_q;

endmodule
